hermes_local_injector: RTL
==========================

Name: hermes_local_injector

Overview:
- Packet injector that drives the LOCAL input port of a Hermes router in each PE.
- Takes a send command (destination X/Y and payload length) plus a payload word stream from the PE memory side.
- Emits a Hermes packet on the router-facing port: header flit, size flit, then payload flits.
- Uses credit-based flow control; an internal FIFO decouples the memory stream from router backpressure.

Parameters:
FLIT_WIDTH, 32, flit and payload word width (>=16)
LEN_WIDTH, 16, width of payload length field (<= FLIT_WIDTH)
FIFO_DEPTH, 4, payload FIFO entries; power of two, >=2

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  send command strobe, sampled in IDLE only
dest_x  in  8  destination router X
dest_y  in  8  destination router Y
len  in  LEN_WIDTH  payload flit count; 0 is legal
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the last flit is accepted by the router
src_data  in  FLIT_WIDTH  payload word from memory side
src_valid  in  1  src_data valid
src_ready  out  1  injector accepts src_data this cycle
tx  out  1  flit valid toward router LOCAL rx
data_o  out  FLIT_WIDTH  flit toward router LOCAL data_i
credit_i  in  1  router LOCAL credit_o; high = may accept a flit
clock_tx  out  1  equals clock

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; tx=0, data_o=0, busy=0, done=0, src_ready=0; FIFO flushed; counters 0. Reset mid-packet abandons the packet with no further flits. The router side is expected to be reset together with this block.
- Flit transfer: a flit is transferred on a rising edge where tx=1 and credit_i=1.
- tx and data_o are registered. While tx=1 and credit_i=0, data_o is held stable. tx never drops without a transfer.
- Header flit: data_o = {zeros, dest_x, dest_y} (dest_x in [15:8], dest_y in [7:0]).
- Size flit: zero-extended payload count.
- FSM states: IDLE, HEADER, SIZE, PAYLOAD, DONE.
- IDLE: on start=1, latch dest_x, dest_y and len, then go to HEADER. Next cycle tx=1 with the header flit. Latency start->first tx is 1 cycle. busy=1 from the cycle after start.
- HEADER: on transfer, go to SIZE. Next flit is the size flit.
- SIZE: on transfer, go to PAYLOAD if len!=0, else to DONE.
- PAYLOAD: tx=1 whenever the output register holds a FIFO word. The output register reloads from the FIFO head in the same cycle as a transfer (back-to-back flits, no bubbles if the FIFO is non-empty). After len payload transfers, go to DONE.
- DONE: done=1 for one cycle, busy=0, tx=0, then go to IDLE.
- start while not IDLE is ignored. start in the DONE cycle is also ignored.
- src_ready = (state in HEADER, SIZE or PAYLOAD) && FIFO not full && words_accepted < len. Prefetch into the FIFO therefore begins during HEADER.
- Words beyond len are never accepted. A FIFO push when src_valid && src_ready.
- FIFO: simultaneous push and pop when full is legal. The pop frees the slot in the same edge, but src_ready is still computed from pre-edge full.
- Counters: words_accepted and flits_sent are LEN_WIDTH wide. len = 2^LEN_WIDTH-1 must not overflow.
- credit_i is ignored whenever tx=0.

Optional Feature:
- Macro: HERMES_INJ_TIMESTAMP_EN.
- When defined: a free-running FLIT_WIDTH counter, cleared by reset and wrapping, is sampled when start is accepted. It is sent as the first payload flit, ahead of the len payload words. The size flit carries len+1, truncated to FLIT_WIDTH. The state order is unchanged; the PAYLOAD count becomes len+1. len=0 yields header, size=1, timestamp.
- When undefined: no counter exists and the size flit equals len.

Test Plan:
- Basic send: dest_x=2, dest_y=1, len=3, payload A0,A1,A2 presented ahead of time, credit_i=1 always -> tx for 5 consecutive cycles with data_o 0x00000201, 0x00000003, A0, A1, A2; done pulses the cycle after A2; busy=0 with it.
- Backpressure: len=4, credit_i held 0 for 6 cycles during SIZE -> tx stays 1 and data_o stays 0x00000004; no flit lost or duplicated; order A0..A3 after credit returns.
- Zero length: len=0 -> exactly 2 flits (header, 0x00000000), then done; src_ready never asserted.
- Source starvation and FIFO full: FIFO_DEPTH=4, len=8, credit_i=0 for 10 cycles -> src_ready drops after 4 pushes. With src_valid gapped, tx drops between payload flits and never outputs stale data; exactly 8 words accepted.
- Control hazards: start pulsed while busy is ignored (no second header). reset asserted mid-payload -> tx=0 and busy=0 immediately. A fresh start afterwards sends a clean header.
- Timestamp (HERMES_INJ_TIMESTAMP_EN): start at counter value 0x15, len=1 -> flits header, 0x00000002, 0x00000015, A0.

Source files
------------

// File: rtl/hermes_local_injector.sv
// Packet injector feeding the LOCAL port of a Hermes router: header, size, then payload flits.
// Optional timestamp flit ahead of the payload when HERMES_INJ_TIMESTAMP_EN is defined.
module hermes_local_injector #(
   parameter int unsigned FLIT_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            dest_x,
   input  logic [7:0]            dest_y,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   input  logic [FLIT_WIDTH-1:0] src_data,
   input  logic                  src_valid,
   output logic                  src_ready,
   output logic                  tx,
   output logic [FLIT_WIDTH-1:0] data_o,
   input  logic                  credit_i,
   output logic                  clock_tx
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_SIZE, S_PAYLOAD, S_DONE
   } state_t;

   state_t                state;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  words_accepted;
   logic [LEN_WIDTH-1:0]  flits_sent;
   logic                  ts_flit;

   logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      fifo_cnt;

   logic                  fifo_full_c;
   logic                  fifo_empty_c;
   logic                  push_c;
   logic                  pop_c;
   logic                  xfer_c;
   logic                  last_c;
   logic [FLIT_WIDTH-1:0] head_c;
   logic [FLIT_WIDTH-1:0] size_flit_c;

   assign clock_tx     = clock;
   assign fifo_full_c  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
   assign fifo_empty_c = (fifo_cnt == '0);
   assign head_c       = mem[rd_ptr];
   assign xfer_c       = tx && credit_i;

   assign src_ready = (state == S_HEADER || state == S_SIZE || state == S_PAYLOAD)
                      && !fifo_full_c && (words_accepted < len_q);
   assign push_c    = src_valid && src_ready;

   // The timestamp flit is the payload flit sent while ts_flit is set.
   assign last_c = ts_flit ? (len_q == '0) : (flits_sent == len_q - LEN_WIDTH'(1));

`ifdef HERMES_INJ_TIMESTAMP_EN
   logic [FLIT_WIDTH-1:0] ts_cnt;
   logic [FLIT_WIDTH-1:0] ts_q;

   assign size_flit_c = FLIT_WIDTH'(LEN_WIDTH'(0) + (LEN_WIDTH+1)'(len_q) + (LEN_WIDTH+1)'(1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) ts_cnt <= '0;
      else        ts_cnt <= ts_cnt + FLIT_WIDTH'(1);
   end
`else
   assign size_flit_c = FLIT_WIDTH'(len_q);
`endif

   // FIFO pop: reload the output register from the head whenever a slot frees up.
   always_comb begin
      pop_c = 1'b0;
      case (state)
`ifndef HERMES_INJ_TIMESTAMP_EN
         S_SIZE:    pop_c = xfer_c && (len_q != '0) && !fifo_empty_c;
`endif
         S_PAYLOAD: pop_c = !fifo_empty_c && (!tx || (xfer_c && !last_c));
         default:   pop_c = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push_c) mem[wr_ptr] <= src_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         len_q          <= '0;
         words_accepted <= '0;
         flits_sent     <= '0;
         ts_flit        <= 1'b0;
         tx             <= 1'b0;
         data_o         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
`ifdef HERMES_INJ_TIMESTAMP_EN
         ts_q           <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (push_c) words_accepted <= words_accepted + LEN_WIDTH'(1);
         case (state)
            S_IDLE: begin
               if (start) begin
                  len_q          <= len;
                  words_accepted <= '0;
                  flits_sent     <= '0;
                  tx             <= 1'b1;
                  data_o         <= FLIT_WIDTH'({dest_x, dest_y});
                  busy           <= 1'b1;
                  state          <= S_HEADER;
`ifdef HERMES_INJ_TIMESTAMP_EN
                  ts_q           <= ts_cnt;
`endif
               end
            end
            S_HEADER: begin
               if (xfer_c) begin
                  data_o <= size_flit_c;
                  state  <= S_SIZE;
               end
            end
            S_SIZE: begin
               if (xfer_c) begin
`ifdef HERMES_INJ_TIMESTAMP_EN
                  data_o  <= ts_q;
                  ts_flit <= 1'b1;
                  state   <= S_PAYLOAD;
`else
                  if (len_q == '0) begin
                     tx    <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     tx    <= pop_c;
                     if (pop_c) data_o <= head_c;
                     state <= S_PAYLOAD;
                  end
`endif
               end
            end
            S_PAYLOAD: begin
               if (xfer_c) begin
                  ts_flit <= 1'b0;
                  if (!ts_flit) flits_sent <= flits_sent + LEN_WIDTH'(1);
                  if (last_c) begin
                     tx    <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     tx <= pop_c;
                     if (pop_c) data_o <= head_c;
                  end
               end else if (!tx && pop_c) begin
                  tx     <= 1'b1;
                  data_o <= head_c;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
